// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI control register bank.
//   FRAME_BITS / DATA_W : frame and register data widths
//   CNT_W               : bit counter width (holds 0..FRAME_BITS)
//   ADDR_*              : register map of the PWM/output control registers
//   spi_state_t         : frame decoder state
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;

  localparam int unsigned ADDR_EN_OUT_LO = 0;
  localparam int unsigned ADDR_EN_OUT_HI = 1;
  localparam int unsigned ADDR_EN_PWM_LO = 2;
  localparam int unsigned ADDR_EN_PWM_HI = 3;
  localparam int unsigned ADDR_DUTY      = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a history flop that
// turns the synchronized level into single-cycle rise/fall pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level (registered)
//   rise_c     : one-cycle pulse on a 0->1 transition of level
//   fall_c     : one-cycle pulse on a 1->0 transition of level
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~hist_q;
  assign fall_c = ~level & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write target holding the five PWM/output control registers.
// Oversamples SCLK/COPI/nCS in the clk domain and decodes 16-bit frames
// {rw, addr[6:0], data[7:0]}, MSB first; rw=1 writes reg[addr].
// Optional feature macro: READBACK_EN (rw=0 frames return reg[addr] on cipo_o).
//   clk, rst_n        : clock, asynchronous active-low reset
//   sclk_i/copi_i/ncs_i : SPI pins, asynchronous to clk
//   cipo_o, cipo_oe_o : read data and its output enable (0 without READBACK_EN)
//   en_reg_out_7_0 .. pwm_duty_cycle : register contents, addresses 0x00..0x04
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_i,
  input  logic        copi_i,
  input  logic        ncs_i,
  output logic        cipo_o,
  output logic        cipo_oe_o,
  output logic [7:0]  en_reg_out_7_0,
  output logic [7:0]  en_reg_out_15_8,
  output logic [7:0]  en_reg_pwm_7_0,
  output logic [7:0]  en_reg_pwm_15_8,
  output logic [7:0]  pwm_duty_cycle
);

  localparam int unsigned NUM_REGS = MAX_ADDR + 1;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl,  ncs_rise,  ncs_fall;

  // Synchronizers reset low so a chip select already held low at reset
  // release does not look like a fresh frame start.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk_i),
    .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi_i),
    .level(copi_lvl), .rise_c(copi_rise), .fall_c(copi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs_i),
    .level(ncs_lvl), .rise_c(ncs_rise), .fall_c(ncs_fall)
  );

  // Edge outputs not needed by the decoder
  logic sync_unused;
  assign sync_unused = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  spi_state_t state_q, state_d;

  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  overrun_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];

  logic                  shift_en_c;
  logic                  frame_rw_c;
  logic [ADDR_W-1:0]     frame_addr_c;
  logic [DATA_W-1:0]     frame_data_c;
  logic                  commit_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An nCS rise in the same cycle as an SCLK rise suppresses the bit
  assign shift_en_c = (state_q == SHIFT) && !ncs_lvl && sclk_rise && !ncs_rise;

  // Shift register and saturating bit counter; overrun marks a 17th+ bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
      shift_q   <= '0;
    end else if (ncs_fall) begin
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else if (shift_en_c) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], copi_lvl};
      if (bit_cnt_q == CNT_W'(FRAME_BITS)) overrun_q <= 1'b1;
      else                                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  assign frame_rw_c   = shift_q[FRAME_BITS-1];
  assign frame_addr_c = shift_q[DATA_W +: ADDR_W];
  assign frame_data_c = shift_q[DATA_W-1:0];

  assign commit_c = (state_q == SHIFT) && ncs_rise && !overrun_q &&
                    (bit_cnt_q == CNT_W'(FRAME_BITS)) && frame_rw_c &&
                    (frame_addr_c <= ADDR_W'(MAX_ADDR));

  // Control register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (commit_c) begin
      regs_q[IDX_W'(frame_addr_c)] <= frame_data_c;
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY];

`ifdef READBACK_EN
  logic [ADDR_W:0]     hdr_c;
  logic                load_c;
  logic [IDX_W-1:0]    load_idx_c;
  logic [DATA_W-1:0]   tx_q;
  logic                cipo_q;
  logic                oe_q;

  // Header as it will look once the 8th bit is shifted in
  assign hdr_c      = {shift_q[ADDR_W-1:0], copi_lvl};
  assign load_idx_c = IDX_W'(hdr_c[ADDR_W-1:0]);
  assign load_c     = shift_en_c && (bit_cnt_q == CNT_W'(ADDR_W)) &&
                      !hdr_c[ADDR_W] && (hdr_c[ADDR_W-1:0] <= ADDR_W'(MAX_ADDR));

  // Read shifter: MSB presented on load, next bit on every SCLK fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
      oe_q   <= 1'b0;
    end else if (ncs_rise || ncs_fall) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
      oe_q   <= 1'b0;
    end else if (load_c) begin
      tx_q   <= regs_q[load_idx_c];
      cipo_q <= regs_q[load_idx_c][DATA_W-1];
      oe_q   <= 1'b1;
    end else if (oe_q && sclk_fall) begin
      tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
      cipo_q <= tx_q[DATA_W-2];
    end
  end

  assign cipo_o    = cipo_q;
  assign cipo_oe_o = oe_q;
`else
  assign cipo_o    = 1'b0;
  assign cipo_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus randomized
// frames checked against a frame-level register model.
module tb_spi_reg_bank;

  logic       clk, rst_n, sclk, copi, ncs;
  logic       cipo_o, cipo_oe_o;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int n_cmp;
  int n_err;

  logic [7:0] exp_regs [5];
  logic       cipo_smp [32];
  logic       oe_smp   [32];

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .copi_i(copi), .ncs_i(ncs),
    .cipo_o(cipo_o), .cipo_oe_o(cipo_oe_o),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  // Frame-level model: only an exact 16-bit write frame to addr 0..4 lands
  function automatic void model_frame(input int n, input logic [31:0] w);
    if (n == 16 && w[15] == 1'b1 && w[14:8] <= 7'd4)
      exp_regs[int'(w[10:8])] = w[7:0];
  endfunction

  // Shift n bits of w (MSB first) without touching nCS; samples cipo at end of each high phase
  task automatic spi_bits(input int n, input logic [31:0] w, input int ph);
    for (int i = 0; i < n; i++) begin
      copi = w[n-1-i];
      repeat (ph) @(negedge clk);
      sclk = 1'b1;
      repeat (ph) @(negedge clk);
      cipo_smp[i] = cipo_o;
      oe_smp[i]   = cipo_oe_o;
      sclk = 1'b0;
    end
  endtask

  // Full frame framed by nCS; returns 4 clk after the nCS rise
  task automatic spi_frame(input int n, input logic [31:0] w, input int ph);
    ncs = 1'b0;
    repeat (ph) @(negedge clk);
    spi_bits(n, w, ph);
    repeat (ph) @(negedge clk);
    ncs = 1'b1;
    model_frame(n, w);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL reset reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
    n_cmp++;
    if ({cipo_o, cipo_oe_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_cipo got %b%b want 00", cipo_o, cipo_oe_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_write();
    spi_frame(16, 32'h80F0, 4);
    n_cmp++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      n_err++;
      $display("FAIL write_reg0 got 0x%02h want 0xf0", en_reg_out_7_0);
    end
    spi_frame(16, 32'h8480, 5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL basic_write reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_invalid_addr();
    spi_frame(16, 32'h85AA, 4);
    spi_frame(16, 32'hFFAA, 4);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL invalid_addr reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_short_long();
    spi_frame(12, 32'h813, 4);
    // Last 16 bits of this 17-bit frame would form a valid write to 0x01
    spi_frame(17, 32'h18155, 4);
    n_cmp++;
    if (en_reg_out_15_8 !== 8'h00) begin
      n_err++;
      $display("FAIL short_long_discard got 0x%02h want 0x00", en_reg_out_15_8);
    end
    spi_frame(16, 32'h813C, 4);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL short_long reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(9, 32'h8255 >> 7, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL mid_reset reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (8) @(negedge clk);
    spi_frame(16, 32'h8255, 4);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL after_reset reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_read_frame();
    spi_frame(16, 32'h83C3, 4);
    spi_frame(16, 32'h0300, 4);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL read_frame reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
`ifdef READBACK_EN
    begin
      logic [7:0] rd;
      rd = 8'hC3;
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (oe_smp[i] !== (i >= 7)) begin
          n_err++;
          $display("FAIL readback_oe bit%0d got %b want %b", i, oe_smp[i], (i >= 7));
        end
        if (i >= 7) begin
          n_cmp++;
          if (cipo_smp[i] !== rd[14-i]) begin
            n_err++;
            $display("FAIL readback_data bit%0d got %b want %b", i, cipo_smp[i], rd[14-i]);
          end
        end
      end
    end
    // Read of an invalid address never enables the driver
    spi_frame(16, 32'h0600, 4);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (oe_smp[i] !== 1'b0) begin
        n_err++;
        $display("FAIL readback_bad_addr bit%0d got %b want 0", i, oe_smp[i]);
      end
    end
`else
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({cipo_smp[i], oe_smp[i]} !== 2'b00) begin
        n_err++;
        $display("FAIL read_tied bit%0d got %b%b want 00", i, cipo_smp[i], oe_smp[i]);
      end
    end
`endif
    n_cmp++;
    if ({cipo_o, cipo_oe_o} !== 2'b00) begin
      n_err++;
      $display("FAIL cipo_after_frame got %b%b want 00", cipo_o, cipo_oe_o);
    end
  endtask

  task automatic test_idle_activity();
    ncs = 1'b1;
    for (int i = 0; i < 40; i++) begin
      copi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL idle_activity reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
    for (int a = 0; a < 5; a++) begin
      logic [31:0] w;
      w = {16'h0, 1'b1, 7'(a), 8'($urandom_range(0, 255))};
      spi_frame(16, w, 4);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dut_reg(i) !== exp_regs[i]) begin
        n_err++;
        $display("FAIL min_phase reg%0d got 0x%02h want 0x%02h", i, dut_reg(i), exp_regs[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int          n, ph, sel;
      logic [15:0] fr;
      logic [6:0]  addr;
      logic [31:0] w;
      sel  = int'($urandom_range(0, 9));
      n    = (sel < 6 || sel == 9) ? 16 : (sel < 8) ? int'($urandom_range(12, 15)) : int'($urandom_range(17, 18));
      ph   = int'($urandom_range(4, 6));
      addr = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
      fr   = {($urandom_range(0, 3) != 0), addr, 8'($urandom_range(0, 255))};
      if (n <= 16) w = 32'(fr) >> (16 - n);
      else         w = (32'(fr) << (n - 16)) | 32'($urandom_range(0, 3));
      spi_frame(n, w, ph);
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (dut_reg(i) !== exp_regs[i]) begin
          n_err++;
          $display("FAIL random%0d n=%0d reg%0d got 0x%02h want 0x%02h", k, n, i, dut_reg(i), exp_regs[i]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    test_reset();
    test_basic_write();
    test_invalid_addr();
    test_short_long();
    test_reset_mid_frame();
    test_read_frame();
    test_idle_activity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
